// File: rtl/mem_access_unit.sv
// Load/store unit: byte/half/word accesses onto a word-wide data memory.
// Loads and word stores take 0 extra cycles; sub-word stores stall once for a read-modify-write.
module mem_access_unit #(
    parameter int ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        addr_err,
    output logic        err_sticky,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_we,
    input  logic [31:0] dm_rdata
);

    typedef enum logic {
        IDLE,
        MERGE
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] merge_q, merge_d;
    logic        err_q;

    logic        misaligned;
    logic        ok_req;
    logic [31:0] word_addr;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sext;
    logic        unused_hi_addr;

    // Only the low ADDR_BITS reach memory, so higher addresses alias silently.
    assign word_addr      = {{(32-ADDR_BITS){1'b0}}, req_addr[ADDR_BITS-1:2], 2'b00};
    assign unused_hi_addr = ^req_addr[31:ADDR_BITS];
    assign ok_req         = req_valid & ~misaligned;
    assign sext           = ~req_unsigned;
    assign lane_b         = dm_rdata[{req_addr[1:0], 3'b000} +: 8];
    assign lane_h         = dm_rdata[{req_addr[1], 4'b0000} +: 16];
    assign err_sticky     = err_q;

    always_comb begin
        misaligned = 1'b1;
        case (req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        load_ext = dm_rdata;
        case (req_size)
            SZ_BYTE: load_ext = {{24{sext & lane_b[7]}}, lane_b};
            SZ_HALF: load_ext = {{16{sext & lane_h[15]}}, lane_h};
            default: load_ext = dm_rdata;
        endcase
    end

    always_comb begin
        merged = dm_rdata;
        if (req_size == SZ_BYTE) begin
            merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        end else begin
            merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        merge_d  = merge_q;
        rdata    = 32'h0;
        stall    = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = word_addr;
        dm_wdata = req_wdata;
        addr_err = 1'b0;

        case (state_q)
            IDLE: begin
                addr_err = req_valid & misaligned;
                if (ok_req) begin
                    if (!req_we) begin
                        rdata = load_ext;
                    end else if (req_size == SZ_WORD) begin
                        dm_we = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        addr_d  = word_addr;
                        merge_d = merged;
                        state_d = MERGE;
                    end
                end
            end
            // The stalled store is still on req_*; it is deliberately not looked at here.
            MERGE: begin
                dm_addr  = addr_q;
                dm_wdata = merge_q;
                dm_we    = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            dm_we   = 1'b0;
            stall   = 1'b0;
            state_d = IDLE;
            addr_d  = 32'h0;
            merge_d = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        addr_q  <= addr_d;
        merge_q <= merge_d;
        if (rst) begin
            err_q <= 1'b0;
        end else if (addr_err) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory and an expectation queue.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        addr_err;
    logic        err_sticky;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic [31:0] dm_rdata;

    logic [31:0] mem [0:1023];
    logic        tb_clr;
    logic        tb_we;
    logic [9:0]  tb_widx;
    logic [31:0] tb_wdata;

    int checks = 0;
    int errors = 0;
    int stall_cnt;

    string       q_tag [$];
    logic [31:0] q_val [$];

    mem_access_unit #(.ADDR_BITS(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rdata       (rdata),
        .stall       (stall),
        .addr_err    (addr_err),
        .err_sticky  (err_sticky),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_we       (dm_we),
        .dm_rdata    (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_addr[11:2]];

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        end else begin
            if (dm_we) mem[dm_addr[11:2]] <= dm_wdata;
            if (tb_we) mem[tb_widx] <= tb_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
        req_valid    = v;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] d);
        tb_we    = 1'b1;
        tb_widx  = idx;
        tb_wdata = d;
        tick();
        tb_we    = 1'b0;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        q_tag.push_back(tag);
        q_val.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] ev;
        checks++;
        if (q_val.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h, no expectation queued", obs);
        end else begin
            tag = q_tag.pop_front();
            ev  = q_val.pop_front();
            assert (obs === ev) else begin
                errors++;
                $error("FAIL %s: observed %h, required %h", tag, obs, ev);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        tb_clr   = 1'b1;
        tb_we    = 1'b0;
        tb_widx  = '0;
        tb_wdata = '0;
        idle();
        tick();
        tick();

        // Reset: idle outputs, and a word store presented during rst must not write.
        settle();
        expect_v("rst_stall", 0);    check(stall);
        expect_v("rst_dm_we", 0);    check(dm_we);
        expect_v("rst_addr_err", 0); check(addr_err);
        expect_v("rst_rdata", 0);    check(rdata);
        expect_v("rst_sticky", 0);   check(err_sticky);
        tick();
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
        settle();
        expect_v("rst_sw_dm_we", 0); check(dm_we);
        tick();
        rst    = 1'b0;
        tb_clr = 1'b0;
        idle();
        tick();

        // Word store then word load.
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        expect_v("sw_stall", 0);
        expect_v("sw_dm_we", 1);
        expect_v("sw_dm_wdata", 32'hDEADBEEF);
        expect_v("sw_dm_addr", 32'h10);
        settle();
        check(stall); check(dm_we); check(dm_wdata); check(dm_addr);
        tick();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        expect_v("lw_stall", 0);
        expect_v("lw_dm_we", 0);
        expect_v("lw_rdata", 32'hDEADBEEF);
        settle();
        check(stall); check(dm_we); check(rdata);
        tick();
        idle();
        tick();

        // Byte store over 0x11223344 at 0x12.
        preload(10'd4, 32'h11223344);
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);
        expect_v("sb_c1_stall", 1);
        expect_v("sb_c1_dm_we", 0);
        settle();
        check(stall); check(dm_we);
        tick();
        expect_v("sb_c2_stall", 0);
        expect_v("sb_c2_dm_we", 1);
        expect_v("sb_c2_wdata", 32'h11AA3344);
        expect_v("sb_c2_addr", 32'h10);
        settle();
        check(stall); check(dm_we); check(dm_wdata); check(dm_addr);
        tick();
        idle();
        expect_v("sb_mem", 32'h11AA3344);
        expect_v("sb_after_dm_we", 0);
        settle();
        check(mem[4]); check(dm_we);
        tick();

        // Halfword store, then signed/unsigned loads.
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF);
        expect_v("sh_c1_stall", 1);
        settle();
        check(stall);
        tick();
        expect_v("sh_c2_wdata", 32'hBEEF0000);
        settle();
        check(dm_wdata);
        tick();
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        expect_v("lh_rdata", 32'hFFFFBEEF);
        settle();
        check(rdata);
        tick();
        drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        expect_v("lhu_rdata", 32'h0000BEEF);
        settle();
        check(rdata);
        tick();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0);
        expect_v("lb_rdata", 32'hFFFFFFBE);
        settle();
        check(rdata);
        tick();
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
        expect_v("lbu_rdata", 32'h000000BE);
        settle();
        check(rdata);
        tick();

        // Misaligned requests.
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
        expect_v("lh_mis_err", 1);
        expect_v("lh_mis_rdata", 0);
        expect_v("lh_mis_stall", 0);
        expect_v("lh_mis_sticky", 0);
        settle();
        check(addr_err); check(rdata); check(stall); check(err_sticky);
        tick();
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678);
        expect_v("sw_mis_err", 1);
        expect_v("sw_mis_dm_we", 0);
        expect_v("sw_mis_sticky", 1);
        settle();
        check(addr_err); check(dm_we); check(err_sticky);
        tick();
        drive(1'b1, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0);
        expect_v("sz11_err", 1);
        expect_v("sz11_dm_we", 0);
        expect_v("sz11_stall", 0);
        settle();
        check(addr_err); check(dm_we); check(stall);
        tick();
        idle();
        expect_v("mis_idle_err", 0);
        expect_v("mis_idle_sticky", 1);
        expect_v("mis_mem", 0);
        settle();
        check(addr_err); check(err_sticky); check(mem[1]);
        tick();

        // Address aliasing above ADDR_BITS.
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h1004, 32'hCAFEF00D);
        expect_v("wrap_sw_addr", 32'h4);
        expect_v("wrap_sw_err", 0);
        expect_v("wrap_sw_dm_we", 1);
        settle();
        check(dm_addr); check(addr_err); check(dm_we);
        tick();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFFF004, 32'h0);
        expect_v("wrap_lw_addr", 32'h4);
        expect_v("wrap_lw_rdata", 32'hCAFEF00D);
        settle();
        check(dm_addr); check(rdata);
        tick();

        // Reset asserted during the write-back cycle of a byte store.
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h40, 32'h00000077);
        expect_v("rstm_c1_stall", 1);
        settle();
        check(stall);
        tick();
        rst = 1'b1;
        expect_v("rstm_dm_we", 0);
        expect_v("rstm_stall", 0);
        settle();
        check(dm_we); check(stall);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
        expect_v("rstm_idle_addr", 32'h44);
        expect_v("rstm_sticky", 0);
        expect_v("rstm_stall", 0);
        expect_v("rstm_dm_we", 0);
        expect_v("rstm_mem", 0);
        settle();
        check(dm_addr); check(err_sticky); check(stall); check(dm_we); check(mem[16]);
        tick();

        // Back-to-back byte stores into one word.
        stall_cnt = 0;
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h30, 32'h00000055);
        settle(); stall_cnt += int'(stall);
        tick();
        settle(); stall_cnt += int'(stall);
        tick();
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h31, 32'h00000066);
        settle(); stall_cnt += int'(stall);
        tick();
        expect_v("b2b_c2_wdata", 32'h00006655);
        settle(); stall_cnt += int'(stall);
        check(dm_wdata);
        tick();
        idle();
        settle(); stall_cnt += int'(stall);
        expect_v("b2b_stalls", 2);
        expect_v("b2b_mem", 32'h00006655);
        check(stall_cnt); check(mem[12]);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
